// File: rtl/fast_bypass_queue.sv
// fast_bypass_queue
// Synchronous FIFO with optional same-cycle write-to-read bypass, full-depth
// storage (wrap-bit pointers), occupancy count and almost-full flag.
// A synchronous kill flushes every stored entry.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset of the pointers
//   kill         synchronous flush; blocks both handshakes in its cycle
//   wready/wvalid/wdata   write side handshake and data
//   rready/rvalid/rdata   read side handshake and head (or bypassed) data
//   count        stored entries, 0..QUEUE_SIZE
//   almost_full  count >= AFULL_THRESH
module fast_bypass_queue #(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned QUEUE_SIZE   = 32,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned AFULL_THRESH = QUEUE_SIZE - 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          kill,
    output logic                          wready,
    input  logic                          wvalid,
    input  logic [DATA_SIZE-1:0]          wdata,
    input  logic                          rready,
    output logic                          rvalid,
    output logic [DATA_SIZE-1:0]          rdata,
    output logic [$clog2(QUEUE_SIZE):0]   count,
    output logic                          almost_full
);

    localparam int unsigned W = $clog2(QUEUE_SIZE);
    localparam logic [W:0] FULL_CNT  = (W+1)'(QUEUE_SIZE);
    localparam logic [W:0] AFULL_CNT = (W+1)'(AFULL_THRESH);
    localparam logic       BYP_EN    = (BYPASS != 0);

    logic [DATA_SIZE-1:0] r_mem [QUEUE_SIZE];
    logic [W:0]           r_head;
    logic [W:0]           r_tail;

    logic [W:0] w_count;
    logic       w_empty;
    logic       w_full;
    logic       w_wr_acc;
    logic       w_bypass;
    logic       w_store;
    logic       w_pop;

    // Wrap bit makes tail-head range 0..QUEUE_SIZE without ambiguity.
    assign w_count = r_tail - r_head;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == FULL_CNT);

    assign wready      = !kill && !w_full;
    assign rvalid      = !kill && (!w_empty || (BYP_EN && wvalid));
    assign rdata       = w_empty ? wdata : r_mem[r_head[W-1:0]];
    assign count       = w_count;
    assign almost_full = (w_count >= AFULL_CNT);

    assign w_wr_acc = wvalid && wready;
    // A word written into an empty queue and consumed in the same cycle is
    // never stored.
    assign w_bypass = BYP_EN && w_empty && rready;
    assign w_store  = w_wr_acc && !w_bypass;
    assign w_pop    = rready && rvalid && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (kill) begin
            r_head <= r_tail;
        end else begin
            if (w_store) r_tail <= r_tail + 1'b1;
            if (w_pop)   r_head <= r_head + 1'b1;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_tail[W-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_fast_bypass_queue.sv
// Testbench for fast_bypass_queue: two instances (BYPASS=1 and BYPASS=0,
// QUEUE_SIZE=4, AFULL_THRESH=3) share the same input stimulus.
// Index 1 is the bypass instance, index 0 the registered-only instance.
module tb_fast_bypass_queue;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          kill;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          rready;

    logic          wr_o [2];
    logic          rv_o [2];
    logic [DW-1:0] rd_o [2];
    logic [2:0]    cnt_o [2];
    logic          af_o [2];

    int checks;
    int failures;

    fast_bypass_queue #(
        .DATA_SIZE(DW), .QUEUE_SIZE(4), .BYPASS(0), .AFULL_THRESH(3)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .kill(kill),
        .wready(wr_o[0]), .wvalid(wvalid), .wdata(wdata),
        .rready(rready), .rvalid(rv_o[0]), .rdata(rd_o[0]),
        .count(cnt_o[0]), .almost_full(af_o[0])
    );

    fast_bypass_queue #(
        .DATA_SIZE(DW), .QUEUE_SIZE(4), .BYPASS(1), .AFULL_THRESH(3)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .kill(kill),
        .wready(wr_o[1]), .wvalid(wvalid), .wdata(wdata),
        .rready(rready), .rvalid(rv_o[1]), .rdata(rd_o[1]),
        .count(cnt_o[1]), .almost_full(af_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; kill = 1'b0; wvalid = 1'b0; wdata = '0; rready = 1'b0;
        #3;
        checks++;
        if (cnt_o[1] !== 3'd0 || af_o[1] !== 1'b0 || wr_o[1] !== 1'b1 || rv_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: count=%0d af=%b wready=%b rvalid=%b, want 0 0 1 0",
                     cnt_o[1], af_o[1], wr_o[1], rv_o[1]);
        end
        wvalid = 1'b1;
        #1;
        checks++;
        if (rv_o[1] !== 1'b1 || rv_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_rvalid_wvalid: byp=%b nobyp=%b, want 1 0", rv_o[1], rv_o[0]);
        end
        wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        wvalid = 1'b1; wdata = 16'h00A5; rready = 1'b1;
        @(negedge clk);
        checks++;
        if (rv_o[1] !== 1'b1 || rd_o[1] !== 16'h00A5) begin
            failures++;
            $display("FAIL bypass_same_cycle: rvalid=%b rdata=%h, want 1 00a5", rv_o[1], rd_o[1]);
        end
        tick();
        wvalid = 1'b0; rready = 1'b0;
        checks++;
        if (cnt_o[1] !== 3'd0) begin
            failures++;
            $display("FAIL bypass_count: count=%0d, want 0", cnt_o[1]);
        end
    endtask

    task automatic test_fill_drain();
        rready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wvalid = 1'b1; wdata = DW'(i);
            tick();
            wvalid = 1'b0;
            checks++;
            if (cnt_o[1] !== 3'(i) || af_o[1] !== (i >= 3) || wr_o[1] !== (i < 4)) begin
                failures++;
                $display("FAIL fill_%0d: count=%0d af=%b wready=%b, want %0d %b %b",
                         i, cnt_o[1], af_o[1], wr_o[1], i, (i >= 3), (i < 4));
            end
        end
        rready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (rv_o[1] !== 1'b1 || rd_o[1] !== DW'(i)) begin
                failures++;
                $display("FAIL drain_%0d: rvalid=%b rdata=%h, want 1 %h", i, rv_o[1], rd_o[1], DW'(i));
            end
            tick();
        end
        rready = 1'b0;
        checks++;
        if (cnt_o[1] !== 3'd0) begin
            failures++;
            $display("FAIL drain_count: count=%0d, want 0", cnt_o[1]);
        end
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] ev [4];
        ev[0] = 16'h11; ev[1] = 16'h12; ev[2] = 16'h13; ev[3] = 16'h77;
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wvalid = 1'b1; wdata = DW'(16'h10 + i);
            tick();
        end
        wvalid = 1'b1; wdata = 16'h77; rready = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_o[1] !== 1'b0 || rv_o[1] !== 1'b1 || rd_o[1] !== 16'h10) begin
            failures++;
            $display("FAIL full_simul_cycle: wready=%b rvalid=%b rdata=%h, want 0 1 0010",
                     wr_o[1], rv_o[1], rd_o[1]);
        end
        tick();
        rready = 1'b0;
        checks++;
        if (cnt_o[1] !== 3'd3 || wr_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL full_simul_after_pop: count=%0d wready=%b, want 3 1", cnt_o[1], wr_o[1]);
        end
        tick();
        wvalid = 1'b0;
        checks++;
        if (cnt_o[1] !== 3'd4) begin
            failures++;
            $display("FAIL full_simul_accept: count=%0d, want 4", cnt_o[1]);
        end
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rv_o[1] !== 1'b1 || rd_o[1] !== ev[i]) begin
                failures++;
                $display("FAIL full_simul_drain_%0d: rvalid=%b rdata=%h, want 1 %h",
                         i, rv_o[1], rd_o[1], ev[i]);
            end
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] sb [$];
        logic [DW-1:0] got;
        int sent = 0;
        int recv = 0;
        for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
            wvalid = (sent < 20);
            wdata  = DW'(16'h100 + sent);
            rready = ((cyc % 6) < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (wvalid && wr_o[1]) begin
                sb.push_back(wdata);
                sent++;
            end
            if (rready && rv_o[1]) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL wrap_spurious: rdata=%h with nothing outstanding", rd_o[1]);
                end else begin
                    got = sb.pop_front();
                    if (rd_o[1] !== got) begin
                        failures++;
                        $display("FAIL wrap_data_%0d: rdata=%h, want %h", recv, rd_o[1], got);
                    end
                end
                recv++;
            end
            tick();
        end
        wvalid = 1'b0; rready = 1'b0;
        checks++;
        if (recv != 20 || cnt_o[1] !== 3'd0) begin
            failures++;
            $display("FAIL wrap_total: received=%0d count=%0d, want 20 0", recv, cnt_o[1]);
        end
    endtask

    task automatic test_kill();
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1; wdata = DW'(16'h31 + i);
            tick();
        end
        kill = 1'b1; wvalid = 1'b1; wdata = 16'h99;
        @(negedge clk);
        checks++;
        if (cnt_o[1] !== 3'd3 || wr_o[1] !== 1'b0 || rv_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL kill_cycle: count=%0d wready=%b rvalid=%b, want 3 0 0",
                     cnt_o[1], wr_o[1], rv_o[1]);
        end
        tick();
        kill = 1'b0; wvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt_o[1] !== 3'd0 || rv_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL kill_after: count=%0d rvalid=%b, want 0 0", cnt_o[1], rv_o[1]);
        end
        wvalid = 1'b1; wdata = 16'h44;
        #1;
        checks++;
        if (rv_o[1] !== 1'b1 || rd_o[1] !== 16'h44) begin
            failures++;
            $display("FAIL kill_no_old_data: rvalid=%b rdata=%h, want 1 0044", rv_o[1], rd_o[1]);
        end
        tick();
        wvalid = 1'b0; rready = 1'b0;
    endtask

    task automatic test_reset_mid();
        rready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = DW'(16'h61 + i);
            tick();
        end
        wvalid = 1'b0;
        checks++;
        if (cnt_o[1] !== 3'd2) begin
            failures++;
            $display("FAIL reset_mid_pre: count=%0d, want 2", cnt_o[1]);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt_o[1] !== 3'd0 || cnt_o[0] !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_async: count=%0d/%0d, want 0/0", cnt_o[1], cnt_o[0]);
        end
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (wr_o[1] !== 1'b1 || cnt_o[1] !== 3'd0 || rv_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release: wready=%b count=%0d rvalid=%b, want 1 0 0",
                     wr_o[1], cnt_o[1], rv_o[1]);
        end
    endtask

    task automatic test_no_bypass();
        wvalid = 1'b1; wdata = 16'h5A; rready = 1'b1;
        @(negedge clk);
        checks++;
        if (rv_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL nobyp_write_cycle: rvalid=%b, want 0", rv_o[0]);
        end
        tick();
        wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (rv_o[0] !== 1'b1 || rd_o[0] !== 16'h5A || cnt_o[0] !== 3'd1) begin
            failures++;
            $display("FAIL nobyp_next_cycle: rvalid=%b rdata=%h count=%0d, want 1 005a 1",
                     rv_o[0], rd_o[0], cnt_o[0]);
        end
        tick();
        rready = 1'b0;
        checks++;
        if (cnt_o[0] !== 3'd0) begin
            failures++;
            $display("FAIL nobyp_drained: count=%0d, want 0", cnt_o[0]);
        end
    endtask

    // Reference: each instance is a bounded list of words; a word offered to
    // an empty bypass queue that is consumed at once never enters the list.
    task automatic test_random();
        logic [DW-1:0] mq [2][$];
        int            sz;
        logic          e_wr, e_rv, e_af, wa, pa;
        logic [DW-1:0] e_rd;
        rst_n = 1'b0; kill = 1'b0; wvalid = 1'b0; rready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            wvalid = ($urandom_range(0, 3) != 0);
            wdata  = DW'($urandom);
            rready = ($urandom_range(0, 2) != 0);
            kill   = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                sz   = mq[d].size();
                e_wr = !kill && (sz < 4);
                e_rv = !kill && (sz != 0 || (d == 1 && wvalid));
                e_af = (sz >= 3);
                e_rd = (sz != 0) ? mq[d][0] : wdata;
                checks++;
                if (wr_o[d] !== e_wr || rv_o[d] !== e_rv || cnt_o[d] !== 3'(sz) || af_o[d] !== e_af ||
                    (e_rv && rd_o[d] !== e_rd)) begin
                    failures++;
                    $display("FAIL random_%0d_dut%0d: wready=%b rvalid=%b count=%0d af=%b rdata=%h, want %b %b %0d %b %h",
                             cyc, d, wr_o[d], rv_o[d], cnt_o[d], af_o[d], rd_o[d],
                             e_wr, e_rv, sz, e_af, e_rd);
                end
                if (kill) begin
                    mq[d].delete();
                end else begin
                    wa = wvalid && e_wr;
                    pa = rready && e_rv;
                    if (!(d == 1 && sz == 0 && wa && rready)) begin
                        if (pa && sz != 0) void'(mq[d].pop_front());
                        if (wa) mq[d].push_back(wdata);
                    end
                end
            end
            tick();
        end
        kill = 1'b0; wvalid = 1'b0; rready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_bypass();
        test_fill_drain();
        test_full_simul();
        test_wrap();
        test_kill();
        test_reset_mid();
        test_no_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fast_bypass_queue.md
# fast_bypass_queue

Parametrised synchronous FIFO with optional same-cycle write-to-read bypass, full-depth storage, an occupancy count and an almost-full flag. It is the general-purpose decoupling queue between pipeline stages, for example fetch→decode and LSU→memory. When BYPASS=1, a word written into an empty queue is readable in the same cycle. A synchronous `kill` flushes the queue on pipeline redirect.

## Interface
- DATA_SIZE, 32, width of one entry in bits
- QUEUE_SIZE, 32, storage depth in entries; a power of two, ≥2; all QUEUE_SIZE entries are usable
- BYPASS, 1, 1 = wdata may appear on rdata in the write cycle; 0 = data is always registered first
- AFULL_THRESH, QUEUE_SIZE-2, count at or above which `almost_full` is asserted; range 1..QUEUE_SIZE
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- kill  in  1  synchronous flush of all stored entries
- wready  out  1  queue can accept a write
- wvalid  in  1  write request
- wdata  in  DATA_SIZE  write data
- rready  in  1  consumer accepts rdata
- rvalid  out  1  rdata is valid
- rdata  out  DATA_SIZE  head entry, or bypassed wdata
- count  out  $clog2(QUEUE_SIZE)+1  number of stored entries, 0..QUEUE_SIZE
- almost_full  out  1  count ≥ AFULL_THRESH

## Operation
- Storage: QUEUE_SIZE×DATA_SIZE array, not reset. head/tail pointers are $clog2(QUEUE_SIZE)+1 bits wide; the MSB is a wrap bit. count = tail − head, computed modulo 2^(W+1).
- wready = !kill && count != QUEUE_SIZE. There is no combinational path from rready to wready.
- rvalid = !kill && (count != 0 || (BYPASS && wvalid)).
- rdata = mem[head[W-1:0]] when count != 0; otherwise wdata. The value is don't-care when rvalid=0.
- Write accepted = wvalid && wready.
  - Bypass case: BYPASS && count==0 && rready. The word is delivered directly and not stored; tail is unchanged.
  - Otherwise: mem[tail] ← wdata and tail ← tail+1.
- Pop = rready && rvalid && count != 0, which advances head ← head+1.
- Simultaneous write and pop with 0<count<QUEUE_SIZE: both pointers advance and count is unchanged.
- Full: wready=0, so a write is refused even if a pop happens in the same cycle. wready rises in the cycle after the pop.
- kill=1 takes priority over everything else:
  - wready and rvalid are forced to 0, so no handshake completes in that cycle.
  - head ← tail, so count=0 on the next cycle.
- Pointer wrap: the low bits index the array and wrap naturally at QUEUE_SIZE; the wrap bit distinguishes full from empty.
- rst_n=0 at any time: head=tail=0 immediately, regardless of clk. Any stored data is lost. Memory contents are not cleared.

## Timing
- Outputs during and after reset:
  - count=0, almost_full=0, wready=1 (with kill=0).
  - rvalid=0 unless BYPASS && wvalid.
- Latency write→read:
  - 0 cycles with BYPASS=1 and the queue empty.
  - Otherwise 1 cycle: the entry is visible on rdata in the cycle after the write, provided it is at the head.
- count and almost_full are registered-derived; they reflect handshakes completed at the previous edge.
- Throughput: one write and one read per cycle sustained.
- Combinational paths:
  - wvalid/wdata → rvalid/rdata, only when BYPASS=1.
  - kill → wready/rvalid.
  - Consumers must not make wvalid depend on rvalid.

## Test plan
- Bypass (BYPASS=1): the queue is empty, wvalid=1, wdata=0xA5, rready=1.
  - Same cycle: rvalid=1 and rdata=0xA5.
  - Next cycle: count=0.
- Fill and drain (QUEUE_SIZE=4, AFULL_THRESH=3, rready=0): write 1,2,3,4.
  - almost_full rises after the 3rd write.
  - After the 4th write: count=4 and wready=0.
  - Then set rready=1: the bench reads 1,2,3,4 in order, and count ends at 0.
- Full with simultaneous activity (count=4, wvalid=1, rready=1):
  - In that cycle: pop occurs, no write, next count=3.
  - Next cycle: wready=1, and the held word is accepted.
- Wrap-around (QUEUE_SIZE=4): stream 20 words with rready toggling every 3 cycles. Output order and values match the input exactly, with no loss or duplication.
- Kill mid-operation: count=3 and kill=1 with wvalid=1.
  - In that cycle: wready=0 and rvalid=0.
  - Next cycle: count=0, rvalid=0, and the old data never appears.
- Reset mid-operation and BYPASS=0:
  - With count=2, assert rst_n=0 between clock edges. count=0 immediately, and wready=1 after release.
  - With BYPASS=0, write 0x5A into the empty queue with rready=1. rvalid=0 in the write cycle; rvalid=1 and rdata=0x5A in the next cycle.
